// File: rtl/bfusion_pkg.sv
// Shared types and helpers for the BitFusion operand feeder.
package bfusion_pkg;

  // Precision configurations as the MAC encodes them.
  typedef enum logic [1:0] {
    CFG_A8W8 = 2'b00,
    CFG_A4W4 = 2'b01,
    CFG_A8W4 = 2'b11
  } cfg_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_FILL  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam int unsigned DEF_MAC_LAT = 3;
  localparam int unsigned WORD_W      = 16;

  // Number of elements merged into one MAC word.
  function automatic logic [2:0] lanes_per_cfg(input cfg_e c);
    logic [2:0] n;
    case (c)
      CFG_A8W4: n = 3'd2;
      CFG_A4W4: n = 3'd4;
      default:  n = 3'd1;
    endcase
    return n;
  endfunction

  // The unused encoding 2'b10 behaves as A8W8.
  function automatic cfg_e map_cfg(input logic [1:0] raw);
    cfg_e c;
    if (raw == 2'b10) c = CFG_A8W8;
    else              c = cfg_e'(raw);
    return c;
  endfunction

endpackage

// File: rtl/bfusion_pack.sv
// Combinational lane merge: drops one element into its lane of the staging word.
module bfusion_pack
  import bfusion_pkg::*;
(
  input  logic [15:0] stage_a_i,
  input  logic [15:0] stage_w_i,
  input  logic [7:0]  act_i,
  input  logic [7:0]  wgt_i,
  input  logic [1:0]  lane_i,
  input  cfg_e        cfg_i,
  output logic [15:0] word_a_o,
  output logic [15:0] word_w_o
);

  // Overlay the element on the staged word at the lane position for this precision.
  always_comb begin
    word_a_o = stage_a_i;
    word_w_o = stage_w_i;
    case (cfg_i)
      CFG_A8W4: begin
        if (lane_i[0]) begin
          word_a_o[15:8] = act_i;
          word_w_o[7:4]  = wgt_i[3:0];
        end else begin
          word_a_o[7:0]  = act_i;
          word_w_o[3:0]  = wgt_i[3:0];
        end
      end
      CFG_A4W4: begin
        word_a_o[{lane_i, 2'b00} +: 4] = act_i[3:0];
        word_w_o[{lane_i, 2'b00} +: 4] = wgt_i[3:0];
      end
      default: begin
        word_a_o[7:0] = act_i;
        word_w_o[7:0] = wgt_i;
      end
    endcase
  end

endmodule

// File: rtl/bfusion_feeder.sv
// Feeds packed activation/weight words to a BitFusion MAC and returns the
// sign-extended dot product once the MAC pipeline has absorbed the last word.
module bfusion_feeder
  import bfusion_pkg::*;
#(
  parameter int unsigned HEADROOM = 4,
  parameter int unsigned MAC_LAT  = DEF_MAC_LAT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 cfg_i,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_act,
  input  logic [7:0]                 in_wgt,
  input  logic                       in_last,
  output logic [15:0]                a_o,
  output logic [15:0]                w_o,
  output logic [1:0]                 cfg_o,
  output logic                       accu_rst_o,
  input  logic [WORD_W+HEADROOM-1:0] z_i,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WORD_W+HEADROOM-1:0] res_data
);

  localparam int unsigned RW = WORD_W + HEADROOM;

  state_e          state_q, state_d;
  cfg_e            cfg_q, cfg_d;
  logic [15:0]     stage_a_q, stage_a_d;
  logic [15:0]     stage_w_q, stage_w_d;
  logic [1:0]      lane_q, lane_d;
  logic [15:0]     a_q, a_d;
  logic [15:0]     w_q, w_d;
  logic [MAC_LAT:0] tok_q, tok_d;
  logic            res_valid_q, res_valid_d;
  logic [RW-1:0]   res_data_q, res_data_d;

  logic [15:0]     merged_a, merged_w;
  logic [2:0]      lanes;
  logic            lane_full;
  logic            capture;

  // Narrower precisions accumulate into fewer significant bits; extend from
  // their true sign position.
  function automatic logic [RW-1:0] sext_res(input logic [RW-1:0] z, input cfg_e c);
    logic [RW-1:0] r;
    case (c)
      CFG_A8W4: r = {{3{z[12+HEADROOM]}}, z[12+HEADROOM:0]};
      CFG_A4W4: r = {{6{z[9+HEADROOM]}}, z[9+HEADROOM:0]};
      default:  r = z;
    endcase
    return r;
  endfunction

  bfusion_pack u_pack (
    .stage_a_i (stage_a_q),
    .stage_w_i (stage_w_q),
    .act_i     (in_act),
    .wgt_i     (in_wgt),
    .lane_i    (lane_q),
    .cfg_i     (cfg_q),
    .word_a_o  (merged_a),
    .word_w_o  (merged_w)
  );

  assign lanes     = lanes_per_cfg(cfg_q);
  assign lane_full = ({1'b0, lane_q} == (lanes - 3'd1));
  // Token bit i set means the current cycle is i cycles after the final word.
  assign capture   = tok_q[MAC_LAT];

  // Next-state, word emission, drain token and result register logic.
  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    stage_a_d   = stage_a_q;
    stage_w_d   = stage_w_q;
    lane_d      = lane_q;
    a_d         = '0;
    w_d         = '0;
    tok_d       = tok_q << 1;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    in_ready    = 1'b0;
    accu_rst_o  = 1'b0;

    if (res_valid_q && res_ready) res_valid_d = 1'b0;
    if (capture) begin
      res_valid_d = 1'b1;
      res_data_d  = sext_res(z_i, cfg_q);
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid && (!res_valid_q || res_ready)) begin
          state_d = ST_CLEAR;
          cfg_d   = map_cfg(cfg_i);
        end
      end
      ST_CLEAR: begin
        accu_rst_o = 1'b1;
        state_d    = ST_FILL;
      end
      ST_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (lane_full || in_last) begin
            a_d       = merged_a;
            w_d       = merged_w;
            stage_a_d = '0;
            stage_w_d = '0;
            lane_d    = '0;
          end else begin
            stage_a_d = merged_a;
            stage_w_d = merged_w;
            lane_d    = lane_q + 2'd1;
          end
          if (in_last) begin
            state_d  = ST_DRAIN;
            tok_d[0] = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (capture) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cfg_q       <= CFG_A8W8;
      stage_a_q   <= '0;
      stage_w_q   <= '0;
      lane_q      <= '0;
      a_q         <= '0;
      w_q         <= '0;
      tok_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      stage_a_q   <= stage_a_d;
      stage_w_q   <= stage_w_d;
      lane_q      <= lane_d;
      a_q         <= a_d;
      w_q         <= w_d;
      tok_q       <= tok_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign a_o       = a_q;
  assign w_o       = w_q;
  assign cfg_o     = cfg_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: doc/bfusion_feeder.md
BFUSION_FEEDER -- requirements
Module: bfusion_feeder

Interface
REQ-001 SHALL have parameter HEADROOM, default 4: accumulator headroom bits of the downstream BitFusion MAC.
REQ-002 SHALL have parameter MAC_LAT, default 3: cycles from a word on a_o/w_o to its contribution being visible on z_i.
REQ-003 SHALL have ports, with clock and reset first:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_i  in  2  precision config: 00 A8W8, 01 A4W4, 11 A8W4, 10 treated as 00
- in_valid  in  1  element valid
- in_ready  out  1  element accepted when in_valid && in_ready
- in_act  in  8  unsigned activation; low nibble only in A4W4
- in_wgt  in  8  signed weight; low nibble only in A4W4/A8W4
- in_last  in  1  last element of dot-product vector
- a_o  out  16  packed activation word to MAC
- w_o  out  16  packed weight word to MAC
- cfg_o  out  2  config to MAC
- accu_rst_o  out  1  accumulator clear to MAC
- z_i  in  16+HEADROOM  MAC accumulator
- res_valid  out  1  result valid
- res_ready  in  1  result consumed
- res_data  out  16+HEADROOM  sign-extended dot product

Function
REQ-004 SHALL implement FSM IDLE -> CLEAR -> FILL -> DRAIN -> IDLE.
REQ-005 IDLE: in_ready=0; go to CLEAR when in_valid && (!res_valid || res_ready); latch cfg_i (10 mapped to 00) into cfg_o at that edge.
REQ-006 CLEAR: exactly 1 cycle; accu_rst_o=1, a_o=w_o=0, in_ready=0; then FILL.
REQ-007 FILL: in_ready=1; one element per handshake; lanes per word: A8W8 1, A8W4 2, A4W4 4.
REQ-008 Packing for lane k: A8W8 a[7:0]=act, w[7:0]=wgt; A8W4 a[8k+7:8k]=act, w[4k+3:4k]=wgt[3:0]; A4W4 a[4k+3:4k]=act[3:0], w[4k+3:4k]=wgt[3:0]; all unused bits 0.
REQ-009 The element filling the last lane, or carrying in_last, SHALL cause the merged word on a_o/w_o in the next cycle for exactly one cycle; missing lanes zero-filled; staging cleared at the same edge.
REQ-010 a_o/w_o SHALL be 0 in every cycle not carrying a word (stall bubbles contribute nothing).
REQ-011 Acceptance with in_last SHALL move the FSM to DRAIN; in_ready=0 in DRAIN.
REQ-012 DRAIN: a token SHALL mark the final-word cycle L; z_i sampled into res_data at the end of cycle L+MAC_LAT; res_valid=1 from the next cycle; then IDLE.
REQ-013 Latency, last-element accept (cycle k) to res_valid: k+2+MAC_LAT (k+5 by default).
REQ-014 res_data sign extension from: A8W8 bit 15+HEADROOM (full width); A8W4 bit 12+HEADROOM; A4W4 bit 9+HEADROOM.
REQ-015 res_valid/res_data SHALL hold until res_ready; res_valid clears on handshake unless a new capture occurs in the same cycle.
REQ-016 cfg_i changes outside IDLE SHALL be ignored; accu_rst_o SHALL be 0 outside CLEAR.

Reset
REQ-017 On rst: state IDLE, staging cleared, token cleared; a_o=0, w_o=0, cfg_o=00, accu_rst_o=0, in_ready=0, res_valid=0, res_data=0.
REQ-018 rst mid-vector SHALL discard the partial vector with no result; the next vector is computed correctly.

Structure
REQ-019 Package bfusion_pkg SHALL hold the cfg enum (CFG_A8W8, CFG_A4W4, CFG_A8W4), the state enum, the lanes-per-config function, and the default MAC_LAT.
REQ-020 The lane merge SHALL be a combinational sub-module bfusion_pack (staging, element, lane index, cfg -> word).

Verification
REQ-021 Bench SHALL pair the feeder with the registered-input BitFusion MAC wrapper (its top level) and cover:
- A8W8, acts 10,20,30, wgts 1,-2,3 -> res_data=60, res_valid at last-accept+5.
- A4W4, 5 elements act 15, wgt -8 -> 2 words (second 1 lane, rest 0), res_data=0xFFDA8 (-600).
- A8W4, acts 255,255, wgts 7,-8 -> one word a=0xFFFF, w=0x0087, res_data=-255.
- res_ready held low 10 cycles with the next vector pending -> res_data stable, in_ready=0, no CLEAR until handshake.
- in_valid gaps mid-vector -> a_o/w_o=0 in bubble cycles, result unchanged.
- rst asserted in FILL -> all outputs at reset values; the following A8W8 vector gives the correct result.
